dev_bus_bridge: RTL and testbench

CPU-side initiator for the peripheral register bus used by the timer and sibling devices. It accepts one word request at a time from the CPU data port, decodes the address into a device window, and issues the access on the shared device bus (ADD_O, DAT_O, per-device WE_O). It returns read data or an error flag through a single-cycle ack, and forwards device interrupt lines to the CPU as registered or latched bits.

---
 rtl/dev_bus_bridge.sv | 148 ++++++++++++++
 tb/tb_dev_bus_bridge.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dev_bus_bridge.sv
// CPU-to-device register bus bridge: one word access per 3 cycles, decode into NDEV
// 16-byte device windows, interrupt forwarding. Optional macro: BRIDGE_IRQ_LATCH_EN.
module dev_bus_bridge #(
    parameter int          NDEV = 2,
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic                 CLK_I,
    input  logic                 RST_N_I,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_wdata,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_ack,
    output logic                 cpu_err,
    output logic [1:0]           ADD_O,
    output logic [31:0]          DAT_O,
    output logic [NDEV-1:0]      WE_O,
    input  logic [32*NDEV-1:0]   DAT_I,
    input  logic [NDEV-1:0]      IRQ_I,
    output logic [NDEV-1:0]      IRQ_O
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] NDEV_K = 4'(NDEV);

    state_t            state, state_nxt;
    logic              hit, dev_ok, loc_ok;
    logic [3:0]        k_in;
    logic [1:0]        off_in;
    logic              we_q, dev_q, loc_q;
    logic [3:0]        k_q;
    logic [NDEV-1:0]   irq_q;
    logic [31:0]       rd_sel;
    logic [31:0]       dev_rd [NDEV];
    logic              unused_addr_bits;

    assign unused_addr_bits = ^cpu_addr[1:0];

    // Decode is done on the incoming address at the accepting edge; the result is
    // the same as decoding the latched address since only the latched copy is used.
    assign hit    = (cpu_addr[31:8] == BASE[31:8]);
    assign k_in   = cpu_addr[7:4];
    assign off_in = cpu_addr[3:2];
    assign dev_ok = hit && (k_in < NDEV_K) && (off_in != 2'd3);
`ifdef BRIDGE_IRQ_LATCH_EN
    assign loc_ok = hit && (k_in == NDEV_K) && (off_in == 2'd0);
`else
    assign loc_ok = 1'b0;
`endif

    for (genvar g = 0; g < NDEV; g++) begin : g_dev_rd
        assign dev_rd[g] = DAT_I[32*g +: 32];
    end

`ifdef BRIDGE_IRQ_LATCH_EN
    logic [NDEV-1:0] pending, clr_q, clr;

    always_comb begin
        clr = '0;
        if (state == ACCESS && loc_q && we_q)
            clr = clr_q;
    end

    // Rising-edge set is OR-ed in after the clear so a same-edge set wins.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            pending <= '0;
            clr_q   <= '0;
        end else begin
            pending <= (pending & ~clr) | (IRQ_I & ~irq_q);
            if (state == IDLE && cpu_req)
                clr_q <= cpu_wdata[NDEV-1:0];
        end
    end

    assign IRQ_O = pending;
`else
    assign IRQ_O = irq_q;
`endif

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NDEV; i++)
            if (k_q == 4'(i))
                rd_sel = dev_rd[i];
`ifdef BRIDGE_IRQ_LATCH_EN
        if (loc_q)
            rd_sel = 32'(pending);
`endif
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        WE_O      = '0;
        case (state)
            IDLE:   if (cpu_req) state_nxt = ACCESS;
            ACCESS: begin
                state_nxt = RESP;
                if (dev_q && we_q)
                    WE_O = NDEV'(1) << k_q;
            end
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            we_q      <= 1'b0;
            dev_q     <= 1'b0;
            loc_q     <= 1'b0;
            k_q       <= '0;
            ADD_O     <= '0;
            DAT_O     <= '0;
            cpu_ack   <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
            irq_q     <= '0;
        end else begin
            irq_q   <= IRQ_I;
            cpu_ack <= (state == RESP);
            if (state == IDLE && cpu_req) begin
                we_q  <= cpu_we;
                dev_q <= dev_ok;
                loc_q <= loc_ok;
                k_q   <= k_in;
                if (dev_ok) begin
                    ADD_O <= off_in;
                    DAT_O <= cpu_wdata;
                end
            end
            if (state == RESP) begin
                cpu_err   <= !(dev_q || loc_q);
                cpu_rdata <= (!we_q && (dev_q || loc_q)) ? rd_sel : '0;
            end
        end
    end

endmodule

// File: tb/tb_dev_bus_bridge.sv
// Self-checking bench for dev_bus_bridge: directed and randomized accesses against
// an address-arithmetic reference model; latched-IRQ checks under BRIDGE_IRQ_LATCH_EN.
module tb_dev_bus_bridge;

    localparam int          NDEV = 2;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] LOCAL_ADDR = BASE + 32'(16 * NDEV);
`ifdef BRIDGE_IRQ_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic                CLK_I = 1'b0;
    logic                RST_N_I = 1'b0;
    logic                cpu_req = 1'b0;
    logic                cpu_we = 1'b0;
    logic [31:0]         cpu_addr = '0;
    logic [31:0]         cpu_wdata = '0;
    logic [31:0]         cpu_rdata;
    logic                cpu_ack;
    logic                cpu_err;
    logic [1:0]          ADD_O;
    logic [31:0]         DAT_O;
    logic [NDEV-1:0]     WE_O;
    logic [32*NDEV-1:0]  DAT_I = '0;
    logic [NDEV-1:0]     IRQ_I = '0;
    logic [NDEV-1:0]     IRQ_O;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [NDEV-1:0] model_pend = '0;

    dev_bus_bridge #(.NDEV(NDEV), .BASE(BASE)) dut (
        .CLK_I(CLK_I), .RST_N_I(RST_N_I), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .ADD_O(ADD_O), .DAT_O(DAT_O),
        .WE_O(WE_O), .DAT_I(DAT_I), .IRQ_I(IRQ_I), .IRQ_O(IRQ_O)
    );

    always #5 CLK_I = ~CLK_I;

    // One complete access: request before edge 0, observe cycles after edges 0..3.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit              hit, dev, loc;
        int unsigned     k, off;
        logic [31:0]     exp_rd;
        logic [NDEV-1:0] exp_we;
        logic [1:0]      prev_add;
        logic [31:0]     prev_dat;
        hit = ((addr >> 8) == (BASE >> 8));
        k   = (addr >> 4) & 32'hF;
        off = (addr >> 2) & 32'h3;
        dev = hit && (k < NDEV) && (off != 3);
        loc = LATCH && hit && (k == NDEV) && (off == 0);
        exp_rd = '0;
        if (!we && dev) exp_rd = DAT_I[32*k +: 32];
        if (!we && loc) exp_rd = 32'(model_pend);
        exp_we = (dev && we) ? NDEV'(1 << k) : '0;
        @(negedge CLK_I);
        prev_add = ADD_O;
        prev_dat = DAT_O;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        @(negedge CLK_I);
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
        checks++; if (WE_O !== exp_we) begin errors++; $display("FAIL we_pulse addr=%h got %b exp %b", addr, WE_O, exp_we); end
        checks++; if (ADD_O !== (dev ? 2'(off) : prev_add)) begin errors++; $display("FAIL add_o addr=%h got %0d exp %0d", addr, ADD_O, dev ? 2'(off) : prev_add); end
        checks++; if (DAT_O !== (dev ? wdata : prev_dat)) begin errors++; $display("FAIL dat_o addr=%h got %h exp %h", addr, DAT_O, dev ? wdata : prev_dat); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL early_ack1 addr=%h got %b exp 0", addr, cpu_ack); end
        @(negedge CLK_I);
        checks++; if (WE_O !== '0) begin errors++; $display("FAIL we_len addr=%h got %b exp 0", addr, WE_O); end
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL early_ack2 addr=%h got %b exp 0", addr, cpu_ack); end
        @(negedge CLK_I);
        checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL ack addr=%h got %b exp 1", addr, cpu_ack); end
        checks++; if (cpu_err !== !(dev || loc)) begin errors++; $display("FAIL err addr=%h got %b exp %b", addr, cpu_err, !(dev || loc)); end
        checks++; if (cpu_rdata !== exp_rd) begin errors++; $display("FAIL rdata addr=%h got %h exp %h", addr, cpu_rdata, exp_rd); end
        if (loc && we) model_pend = model_pend & ~wdata[NDEV-1:0];
        @(negedge CLK_I);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL ack_len addr=%h got %b exp 0", addr, cpu_ack); end
    endtask

    task automatic test_reset();
        RST_N_I = 1'b0;
        IRQ_I = '1;
        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I);
        checks++; if ({cpu_rdata, cpu_ack, cpu_err} !== '0) begin errors++; $display("FAIL reset_resp got %h/%b/%b exp 0", cpu_rdata, cpu_ack, cpu_err); end
        checks++; if ({ADD_O, DAT_O, WE_O} !== '0) begin errors++; $display("FAIL reset_bus got %h/%h/%b exp 0", ADD_O, DAT_O, WE_O); end
        checks++; if (IRQ_O !== '0) begin errors++; $display("FAIL reset_irq got %b exp 0", IRQ_O); end
        IRQ_I = '0;
        RST_N_I = 1'b1;
        model_pend = '0;
    endtask

    task automatic test_directed();
        run_access(1'b1, 32'h0000_7F00, 32'h0000_0009);
        DAT_I = '0;
        DAT_I[63:32] = 32'h0000_0123;
        run_access(1'b0, 32'h0000_7F18, 32'h0);
        run_access(1'b1, 32'h0000_7F0C, 32'hDEAD_BEEF);
        run_access(1'b0, 32'h0000_8000, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NDEV; i++) DAT_I[32*i +: 32] = $urandom;
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            else addr = BASE + $urandom_range(0, 63);
            run_access(1'($urandom), addr, $urandom);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK_I);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7F00;
        for (int e = 0; e < 9; e++) begin
            @(posedge CLK_I);
            #1;
            checks++; if (cpu_ack !== (e % 3 == 2)) begin errors++; $display("FAIL b2b_ack edge=%0d got %b exp %b", e, cpu_ack, (e % 3 == 2)); end
            cpu_addr = (e % 2 == 0) ? 32'h0000_7F14 : 32'h0000_7F00;
        end
        cpu_req = 1'b0;
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", cpu_err); end
        @(negedge CLK_I);
    endtask

    task automatic test_reset_abort();
        @(negedge CLK_I);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_7F00; cpu_wdata = 32'h5;
        @(posedge CLK_I);
        #1;
        cpu_req = 1'b0;
        checks++; if (WE_O !== NDEV'(1)) begin errors++; $display("FAIL abort_pre_we got %b exp 01", WE_O); end
        #2 RST_N_I = 1'b0;
        #1;
        checks++; if ({cpu_rdata, cpu_ack, cpu_err, ADD_O, DAT_O, WE_O, IRQ_O} !== '0) begin errors++; $display("FAIL abort_outputs ack=%b we=%b dat=%h exp all 0", cpu_ack, WE_O, DAT_O); end
        @(negedge CLK_I);
        RST_N_I = 1'b1;
        model_pend = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK_I);
            checks++; if ({cpu_ack, WE_O} !== '0) begin errors++; $display("FAIL abort_quiet cyc=%0d ack=%b we=%b exp 0", c, cpu_ack, WE_O); end
        end
        run_access(1'b1, 32'h0000_7F14, 32'h0000_00A5);
    endtask

    task automatic test_irq();
        logic [NDEV-1:0] prev, v, exp_o;
        prev = IRQ_I;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK_I);
            v = NDEV'($urandom);
            IRQ_I = v;
            @(negedge CLK_I);
            model_pend = model_pend | (v & ~prev);
            exp_o = LATCH ? model_pend : v;
            checks++; if (IRQ_O !== exp_o) begin errors++; $display("FAIL irq_o n=%0d got %b exp %b", n, IRQ_O, exp_o); end
            prev = v;
        end
        IRQ_I = '0;
        @(negedge CLK_I);
    endtask

`ifdef BRIDGE_IRQ_LATCH_EN
    task automatic test_irq_latch();
        run_access(1'b1, LOCAL_ADDR, 32'hFFFF_FFFF);
        @(negedge CLK_I); IRQ_I = 2'b10;
        @(negedge CLK_I); IRQ_I = 2'b00;
        model_pend = model_pend | 2'b10;
        repeat (2) begin
            @(negedge CLK_I);
            checks++; if (IRQ_O[1] !== 1'b1) begin errors++; $display("FAIL latch_hold got %b exp 1", IRQ_O[1]); end
        end
        run_access(1'b0, LOCAL_ADDR, 32'h0);
        run_access(1'b1, LOCAL_ADDR, 32'h2);
        checks++; if (IRQ_O !== model_pend) begin errors++; $display("FAIL latch_clear got %b exp %b", IRQ_O, model_pend); end
        @(negedge CLK_I);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = LOCAL_ADDR; cpu_wdata = 32'h2;
        @(negedge CLK_I);
        cpu_req = 1'b0; IRQ_I = 2'b10;
        @(negedge CLK_I);
        checks++; if (IRQ_O[1] !== 1'b1) begin errors++; $display("FAIL latch_set_wins got %b exp 1", IRQ_O[1]); end
        @(negedge CLK_I);
        checks++; if ({cpu_ack, cpu_err} !== 2'b10) begin errors++; $display("FAIL latch_ack got %b%b exp 10", cpu_ack, cpu_err); end
        model_pend = model_pend | 2'b10;
        IRQ_I = '0;
        run_access(1'b0, LOCAL_ADDR, 32'h0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_irq();
`ifdef BRIDGE_IRQ_LATCH_EN
        test_irq_latch();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
